// File: rtl/addsub_seq_cla_pkg.sv
// addsub_seq_cla_pkg: shared state encodings, mode constants and clog2 helper
package addsub_seq_cla_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/addsub_seq_cla_if.sv
// addsub_seq_cla_if: operand/result valid-ready bus of the sequential add/sub unit
interface addsub_seq_cla_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovr;
  logic             zero;
  logic             neg;
  modport master (output in_valid, a, b, m, cin, out_ready,
                  input in_ready, out_valid, s, cout, ovr, zero, neg);
  modport slave  (input in_valid, a, b, m, cin, out_ready,
                  output in_ready, out_valid, s, cout, ovr, zero, neg);
endinterface

// File: rtl/addsub_seq_cla_slice.sv
// cla_slice: combinational N-bit carry-lookahead adder exporting carry into its MSB
module cla_slice #(parameter int N = 4) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic         ci_i,
  output logic [N-1:0] sum_o,
  output logic         co_o,
  output logic         c_msb_o
);
  logic [N-1:0] g, p;
  logic [N:0]   c;
  logic         pp;
  assign g = x_i & y_i;
  assign p = x_i ^ y_i;
  always_comb begin
    c = '0;
    pp = 1'b0;
    c[0] = ci_i;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci_i);
    end
  end
  assign sum_o   = p ^ c[N-1:0];
  assign co_o    = c[N];
  assign c_msb_o = c[N-1];
endmodule

// File: rtl/addsub_seq_cla.sv
// addsub_seq_cla: multi-cycle add/sub, one CHUNK-bit CLA slice per clock, LSB first.
// Define ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module addsub_seq_cla
  import addsub_seq_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  addsub_seq_cla_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = clog2(NCHUNK) < 1 ? 1 : clog2(NCHUNK);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d, res, fin;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovr_q, ovr_d, zero_q, zero_d, neg_q, neg_d;
  logic [CHUNK-1:0] sum;
  logic             co, c_msb;
  cla_slice #(.N(CHUNK)) u_slice (
    .x_i(a_q[CHUNK-1:0]), .y_i(b_q[CHUNK-1:0]), .ci_i(c_q),
    .sum_o(sum), .co_o(co), .c_msb_o(c_msb)
  );
  // operands shift right each cycle; sum slices enter the accumulator from the top
  assign res = (acc_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
`ifdef ADDSUB_SATURATE_EN
  // on overflow the wrapped sign is inverted, so it tells the overflow direction
  assign fin = (c_msb ^ co) ? {~res[WIDTH-1], {(WIDTH-1){res[WIDTH-1]}}} : res;
`else
  assign fin = res;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    c_d = c_q;
    cnt_d = cnt_q;
    s_d = s_q;
    cout_d = cout_q;
    ovr_d = ovr_q;
    zero_d = zero_q;
    neg_d = neg_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_RUN;
        a_d = bus.a;
        b_d = bus.m == MODE_SUB ? ~bus.b : bus.b;
        c_d = (bus.m == MODE_SUB) | bus.cin;
        cnt_d = '0;
      end
      ST_RUN: begin
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        acc_d = res;
        c_d = co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = ST_DONE;
          s_d = fin;
          cout_d = co;
          ovr_d = c_msb ^ co;
          zero_d = fin == '0;
          neg_d = fin[WIDTH-1];
        end
      end
      ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
      ovr_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      cout_q <= cout_d;
      ovr_q <= ovr_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
    end
  end
  assign bus.in_ready  = state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovr  = ovr_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
endmodule
